ahb_input_stage_hold: RTL and testbench
=======================================

# ahb_input_stage_hold

Master-side input stage for the sparse AHB bus matrix. It sits between one AHB-Lite master port and the address decoder/output arbiters, and produces the requests those arbiters consume. When the selected output arbiter does not grant the address in the cycle it is presented, the stage captures the address phase into a holding register. It then stalls the master until the transfer is accepted, and routes the granted slave's data-phase response back to the master.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of HADDRS/HADDRI

Ports:
- HCLK  in  1  AHB system clock
- HRESET  in  1  reset; synchronous, active-high
- HSELS  in  1  master-port select
- HADDRS  in  ADDR_WIDTH  master address
- HTRANSS  in  2  master transfer type
- HWRITES  in  1  master write
- HSIZES  in  3  master size
- HBURSTS  in  3  master burst type
- HPROTS  in  4  master protection
- HMASTLOCKS  in  1  master lock
- HREADYS  in  1  master-side bus HREADY
- HADDRI, HWRITEI, HSIZEI, HBURSTI, HPROTI, HMASTLOCKI  out  as inputs  address phase presented to decoder/arbiters
- HTRANSI  out  2  transfer type presented downstream
- active_trans  out  1  a NONSEQ/SEQ transfer is presented downstream (drives the req_portN logic)
- held_tran  out  1  holding register is occupied
- addr_in_phase  in  1  an output arbiter accepted this port's address this cycle (granted, HREADYM high)
- data_in_phase  in  1  this port owns a data phase at some output
- HREADYOUTM  in  1  ready from the output carrying this port's data phase
- HRESPM  in  1  response from that output
- HREADYOUTS  out  1  ready to master
- HRESPS  out  1  response to master

## Operation
- live_valid = HSELS & HTRANSS[1] & HREADYS. This is a sampled NONSEQ/SEQ address phase.
- Capture: on a rising HCLK edge with live_valid=1 and addr_in_phase=0, all address/control inputs load into the holding register and held_tran becomes 1.
- Release: on an edge with held_tran=1 and addr_in_phase=1, held_tran becomes 0.
- Simultaneous release and new capture cannot occur, because HREADYOUTS=0 while held.
- Output mux: held_tran=1 drives the register onto the *I outputs. Otherwise the live inputs pass through combinationally.
  - HTRANSI = IDLE when held_tran=0 and HSELS=0.
- active_trans = held_tran | (HSELS & HTRANSS[1]).
  - BUSY (01) is passed on HTRANSI with active_trans=0, so the arbiter burst counters pause.
- HREADYOUTS:
  - data_in_phase=1: HREADYOUTM.
  - else held_tran=1: 0.
  - else: 1.
- HRESPS = data_in_phase ? HRESPM : 0.
- A two-cycle ERROR is forwarded unchanged: cycle 1 is HRESPM=1/HREADYOUTM=0, cycle 2 is 1/1.
- State: IDLE (held_tran=0) and HOLD (held_tran=1). The only transitions are capture and release, plus the cancel path under Configuration.
- A held NONSEQ with HMASTLOCKS=1 keeps HMASTLOCKI=1 for its entire hold, so lock is never dropped while pending.
- Reset mid-hold: the next edge with HRESET=1 clears held_tran; no transfer is presented afterwards.

## Timing
- Reset values:
  - held_tran=0, holding register all zeros.
  - HREADYOUTS=1, HRESPS=0.
  - *I outputs follow the live inputs.
  - active_trans = HSELS & HTRANSS[1].
- Granted in the same cycle: zero added latency; the path is combinational and no register is loaded.
- Not granted:
  - The held address appears on *I from the next cycle.
  - HREADYOUTS is low from that cycle onward, unless a prior data phase is still completing via data_in_phase.
- Release edge: the next cycle presents the live inputs again.
  - The data phase of the released transfer begins that cycle, and HREADYOUTS follows HREADYOUTM.
- All state updates occur on the rising HCLK edge only.

## Configuration
- AHB_INPUT_STAGE_ERR_CANCEL_EN defined: the stage supports cancelling a held transfer after an error.
  - Condition: an edge with held_tran=1, data_in_phase=1, HRESPM=1, HREADYOUTM=0 and HTRANSS=IDLE.
  - Effect: held_tran clears without a grant (the master abandoned its pending transfer during the ERROR first cycle).
  - HTRANSI reads IDLE from the next cycle.
- Not defined: a held transfer is released only by addr_in_phase, and the ERROR cancel path is absent.

## Test plan
- Immediate grant: NONSEQ to 0x0000_1000 with addr_in_phase=1 in the same cycle -> HADDRI=0x0000_1000 that cycle, held_tran stays 0, HREADYOUTS=1.
- Hold 3 cycles: NONSEQ to 0x2000_0040, addr_in_phase=0 for 3 cycles then 1 -> held_tran=1 and HADDRI=0x2000_0040 for 3 cycles while the master inputs change; HREADYOUTS=0; held_tran=0 after the grant edge.
- Response routing: data_in_phase=1, HREADYOUTM=0 for 2 cycles then 1, HRESPM=0 -> HREADYOUTS=0,0,1, HRESPS=0 throughout.
- ERROR cancel (macro defined): held transfer, then HRESPM=1/HREADYOUTM=0 with HTRANSS=IDLE -> held_tran=0 and HTRANSI=00 next cycle. With the macro undefined, held_tran stays 1 until addr_in_phase.
- BUSY in burst: INCR4 NONSEQ granted, then BUSY, then SEQ -> during BUSY HTRANSI=01 and active_trans=0; on SEQ active_trans=1.
- Reset mid-hold: assert HRESET for one edge while held_tran=1 -> held_tran=0, HREADYOUTS=1, HRESPS=0 on the following cycle.

Source files
------------

// File: rtl/ahb_input_stage_hold.sv
// AHB-Lite master-side input stage: holds an ungranted address phase and stalls the master until accepted.
// Optional macro AHB_INPUT_STAGE_ERR_CANCEL_EN enables dropping a held transfer during an ERROR first cycle.
module ahb_input_stage_hold #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    output logic [ADDR_WIDTH-1:0] HADDRI,
    output logic [1:0]            HTRANSI,
    output logic                  HWRITEI,
    output logic [2:0]            HSIZEI,
    output logic [2:0]            HBURSTI,
    output logic [3:0]            HPROTI,
    output logic                  HMASTLOCKI,
    output logic                  active_trans,
    output logic                  held_tran,
    input  logic                  addr_in_phase,
    input  logic                  data_in_phase,
    input  logic                  HREADYOUTM,
    input  logic                  HRESPM,
    output logic                  HREADYOUTS,
    output logic                  HRESPS
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
    logic [1:0]            htrans_q, htrans_d;
    logic                  hwrite_q, hwrite_d;
    logic [2:0]            hsize_q, hsize_d;
    logic [2:0]            hburst_q, hburst_d;
    logic [3:0]            hprot_q, hprot_d;
    logic                  hmastlock_q, hmastlock_d;
    logic                  live_valid;

    assign live_valid = HSELS & HTRANSS[1] & HREADYS;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            haddr_q     <= '0;
            htrans_q    <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hburst_q    <= '0;
            hprot_q     <= '0;
            hmastlock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hburst_q    <= hburst_d;
            hprot_q     <= hprot_d;
            hmastlock_q <= hmastlock_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hburst_d    = hburst_q;
        hprot_d     = hprot_q;
        hmastlock_d = hmastlock_q;
        case (state_q)
            ST_IDLE: begin
                if (live_valid && !addr_in_phase) begin
                    state_d     = ST_HOLD;
                    haddr_d     = HADDRS;
                    htrans_d    = HTRANSS;
                    hwrite_d    = HWRITES;
                    hsize_d     = HSIZES;
                    hburst_d    = HBURSTS;
                    hprot_d     = HPROTS;
                    hmastlock_d = HMASTLOCKS;
                end
            end
            ST_HOLD: begin
                if (addr_in_phase) begin
                    state_d = ST_IDLE;
`ifdef AHB_INPUT_STAGE_ERR_CANCEL_EN
                // Master abandoned the pending transfer in the first ERROR cycle.
                end else if (data_in_phase && HRESPM && !HREADYOUTM && (HTRANSS == 2'b00)) begin
                    state_d = ST_IDLE;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        held_tran = (state_q == ST_HOLD);
        if (held_tran) begin
            HADDRI     = haddr_q;
            HTRANSI    = htrans_q;
            HWRITEI    = hwrite_q;
            HSIZEI     = hsize_q;
            HBURSTI    = hburst_q;
            HPROTI     = hprot_q;
            HMASTLOCKI = hmastlock_q;
        end else begin
            HADDRI     = HADDRS;
            HTRANSI    = HSELS ? HTRANSS : 2'b00;
            HWRITEI    = HWRITES;
            HSIZEI     = HSIZES;
            HBURSTI    = HBURSTS;
            HPROTI     = HPROTS;
            HMASTLOCKI = HMASTLOCKS;
        end
        // BUSY keeps active_trans low so downstream burst counters pause.
        active_trans = held_tran | (HSELS & HTRANSS[1]);
        if (data_in_phase) begin
            HREADYOUTS = HREADYOUTM;
        end else if (held_tran) begin
            HREADYOUTS = 1'b0;
        end else begin
            HREADYOUTS = 1'b1;
        end
        HRESPS = data_in_phase ? HRESPM : 1'b0;
    end

endmodule

// File: tb/tb_ahb_input_stage_hold.sv
// Scoreboard bench for ahb_input_stage_hold; expectations adapt to AHB_INPUT_STAGE_ERR_CANCEL_EN.
module tb_ahb_input_stage_hold;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic [31:0] HADDRI;
    logic [1:0]  HTRANSI;
    logic        HWRITEI;
    logic [2:0]  HSIZEI;
    logic [2:0]  HBURSTI;
    logic [3:0]  HPROTI;
    logic        HMASTLOCKI;
    logic        active_trans;
    logic        held_tran;
    logic        addr_in_phase;
    logic        data_in_phase;
    logic        HREADYOUTM;
    logic        HRESPM;
    logic        HREADYOUTS;
    logic        HRESPS;

    ahb_input_stage_hold #(.ADDR_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS),
        .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
        .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
        .HADDRI(HADDRI), .HTRANSI(HTRANSI), .HWRITEI(HWRITEI), .HSIZEI(HSIZEI),
        .HBURSTI(HBURSTI), .HPROTI(HPROTI), .HMASTLOCKI(HMASTLOCKI),
        .active_trans(active_trans), .held_tran(held_tran),
        .addr_in_phase(addr_in_phase), .data_in_phase(data_in_phase),
        .HREADYOUTM(HREADYOUTM), .HRESPM(HRESPM),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        string       tag;
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic        held;
        logic        active;
        logic        rdyo;
        logic        resp;
        logic        lock;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   cancel_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                       input logic rdy, input logic aip, input logic dip,
                       input logic rdym, input logic respm, input logic lock);
        HSELS         = sel;
        HTRANSS       = trans;
        HADDRS        = addr;
        HREADYS       = rdy;
        addr_in_phase = aip;
        data_in_phase = dip;
        HREADYOUTM    = rdym;
        HRESPM        = respm;
        HMASTLOCKS    = lock;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] addr, input logic [1:0] trans,
                              input logic held, input logic act, input logic rdyo,
                              input logic resp, input logic lock);
        exp_t e;
        e.tag = tag; e.haddr = addr; e.htrans = trans; e.held = held;
        e.active = act; e.rdyo = rdyo; e.resp = resp; e.lock = lock;
        exp_q.push_back(e);
    endtask

    // Sample on the falling edge, then advance to just after the next rising edge.
    task automatic step();
        exp_t e;
        @(negedge HCLK);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.tag, ".haddri"}, HADDRI, e.haddr);
            check({e.tag, ".htransi"}, {30'd0, HTRANSI}, {30'd0, e.htrans});
            check({e.tag, ".held"}, {31'd0, held_tran}, {31'd0, e.held});
            check({e.tag, ".active"}, {31'd0, active_trans}, {31'd0, e.active});
            check({e.tag, ".hreadyouts"}, {31'd0, HREADYOUTS}, {31'd0, e.rdyo});
            check({e.tag, ".hresps"}, {31'd0, HRESPS}, {31'd0, e.resp});
            check({e.tag, ".lock"}, {31'd0, HMASTLOCKI}, {31'd0, e.lock});
        end
        @(posedge HCLK);
        #1;
    endtask

    initial begin
`ifdef AHB_INPUT_STAGE_ERR_CANCEL_EN
        cancel_en = 1'b1;
`else
        cancel_en = 1'b0;
`endif
        HRESET  = 1'b1;
        HWRITES = 1'b0;
        HSIZES  = 3'd2;
        HBURSTS = 3'd0;
        HPROTS  = 4'h3;
        drv(0, 2'b00, 32'h0, 1, 0, 0, 1, 0, 0);
        @(posedge HCLK); #1;
        expect_out("reset", 32'h0, 2'b00, 0, 0, 1, 0, 0);
        step();
        HRESET = 1'b0;

        // Immediate grant: combinational pass-through, nothing captured.
        drv(1, 2'b10, 32'h0000_1000, 1, 1, 0, 1, 0, 0);
        expect_out("grant", 32'h0000_1000, 2'b10, 0, 1, 1, 0, 0);
        step();
        drv(0, 2'b00, 32'h0000_0010, 1, 0, 0, 1, 0, 0);
        expect_out("grant_after", 32'h0000_0010, 2'b00, 0, 0, 1, 0, 0);
        step();

        // Not granted: hold three cycles, grant on the fourth held cycle.
        drv(1, 2'b10, 32'h2000_0040, 1, 0, 0, 1, 0, 1);
        expect_out("hold_present", 32'h2000_0040, 2'b10, 0, 1, 1, 0, 1);
        step();
        for (int i = 0; i < 4; i++) begin
            drv(1, 2'b11, 32'hDEAD_0000 + 32'(i), 0, (i == 3), 0, 1, 0, 0);
            expect_out($sformatf("hold%0d", i), 32'h2000_0040, 2'b10, 1, 1, 0, 0, 1);
            step();
        end
        drv(0, 2'b00, 32'h0000_0033, 1, 0, 1, 1, 0, 0);
        expect_out("released", 32'h0000_0033, 2'b00, 0, 0, 1, 0, 0);
        step();

        // Response routing, including a two-cycle ERROR.
        for (int i = 0; i < 3; i++) begin
            drv(0, 2'b00, 32'h0, 1, 0, 1, (i == 2), 0, 0);
            expect_out($sformatf("resp%0d", i), 32'h0, 2'b00, 0, 0, (i == 2), 0, 0);
            step();
        end
        drv(0, 2'b00, 32'h0, 1, 0, 1, 0, 1, 0);
        expect_out("err1", 32'h0, 2'b00, 0, 0, 0, 1, 0);
        step();
        drv(0, 2'b00, 32'h0, 1, 0, 1, 1, 1, 0);
        expect_out("err2", 32'h0, 2'b00, 0, 0, 1, 1, 0);
        step();

        // ERROR cancel of a held transfer.
        drv(1, 2'b10, 32'h0000_4000, 1, 0, 0, 1, 0, 0);
        expect_out("cx_present", 32'h0000_4000, 2'b10, 0, 1, 1, 0, 0);
        step();
        drv(1, 2'b00, 32'h0000_4100, 0, 0, 1, 0, 1, 0);
        expect_out("cx_err1", 32'h0000_4000, 2'b10, 1, 1, 0, 1, 0);
        step();
        drv(1, 2'b00, 32'h0000_4100, 0, 0, 1, 1, 1, 0);
        expect_out("cx_err2", cancel_en ? 32'h0000_4100 : 32'h0000_4000,
                   cancel_en ? 2'b00 : 2'b10, !cancel_en, !cancel_en, 1, 1, 0);
        step();
        drv(1, 2'b00, 32'h0000_4100, 0, 1, 0, 1, 0, 0);
        expect_out("cx_grant", cancel_en ? 32'h0000_4100 : 32'h0000_4000,
                   cancel_en ? 2'b00 : 2'b10, !cancel_en, !cancel_en, cancel_en, 0, 0);
        step();
        drv(0, 2'b00, 32'h0, 1, 0, 0, 1, 0, 0);
        expect_out("cx_done", 32'h0, 2'b00, 0, 0, 1, 0, 0);
        step();

        // INCR4 burst with a BUSY beat.
        HBURSTS = 3'd3;
        drv(1, 2'b10, 32'h0000_5000, 1, 1, 0, 1, 0, 0);
        expect_out("burst_nseq", 32'h0000_5000, 2'b10, 0, 1, 1, 0, 0);
        step();
        drv(1, 2'b01, 32'h0000_5004, 1, 0, 0, 1, 0, 0);
        expect_out("burst_busy", 32'h0000_5004, 2'b01, 0, 0, 1, 0, 0);
        step();
        drv(1, 2'b11, 32'h0000_5004, 1, 1, 0, 1, 0, 0);
        expect_out("burst_seq", 32'h0000_5004, 2'b11, 0, 1, 1, 0, 0);
        step();
        HBURSTS = 3'd0;

        // Reset while a transfer is held.
        drv(1, 2'b10, 32'h0000_6000, 1, 0, 0, 1, 0, 1);
        expect_out("rst_present", 32'h0000_6000, 2'b10, 0, 1, 1, 0, 1);
        step();
        HRESET = 1'b1;
        drv(1, 2'b10, 32'h0000_6000, 0, 0, 0, 1, 0, 0);
        expect_out("rst_held", 32'h0000_6000, 2'b10, 1, 1, 0, 0, 1);
        step();
        HRESET = 1'b0;
        drv(0, 2'b00, 32'h0000_0070, 1, 0, 0, 1, 0, 0);
        expect_out("rst_after", 32'h0000_0070, 2'b00, 0, 0, 1, 0, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
